// File: rtl/cmd_spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_spi_rx_fifo
// Brief    : Mode-0 SPI slave byte receiver feeding a byte FIFO; the control
//            unit reads the head byte and pops it with a single-cycle next.
// Options  : CMD_RX_DROP_COUNT_EN adds a 16-bit saturating dropped-byte count.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_spi_rx_fifo #(
   parameter int FIFO_DEPTH  = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         spi_sck,
   input  logic                         spi_cs_n,
   input  logic                         spi_mosi,
   output logic [7:0]                   out_byte,
   output logic                         out_valid,
   input  logic                         next,
   output logic                         overflow,
   input  logic                         clear_overflow,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         rx_active
`ifdef CMD_RX_DROP_COUNT_EN
   ,
   output logic [15:0]                  dropped_count
`endif
);

   localparam int                c_AW    = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0]     c_DEPTH = (c_AW+1)'(FIFO_DEPTH);
   localparam int                c_FW    = $clog2(SYNC_STAGES + 2);
   localparam logic [c_FW-1:0]   c_FLUSH = c_FW'(SYNC_STAGES + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Synchroniser chains plus one delayed copy of the last stage for edge detect
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_sck_d;
   logic                   r_cs_d;
   logic [c_FW-1:0]        r_flush_cnt;

   logic                   w_sck;
   logic                   w_cs_n;
   logic                   w_mosi;
   logic                   w_sync_ok;
   logic                   w_sck_rise;
   logic                   w_cs_fall;
   logic                   w_cs_rise;

   // Receiver state
   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [2:0]             r_bit_cnt;
   logic [2:0]             w_bit_cnt_nxt;
   logic [7:0]             r_shift;
   logic [7:0]             w_shift_nxt;
   logic [7:0]             w_push_byte;
   logic                   w_push;

   // FIFO state
   logic [7:0]             r_mem [0:FIFO_DEPTH-1];
   logic [c_AW-1:0]        r_wr_ptr;
   logic [c_AW-1:0]        r_rd_ptr;
   logic [c_AW:0]          r_level;
   logic                   r_overflow;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_wr_en;
   logic                   w_drop;

   assign w_sck  = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // Edges are ignored until the chains have flushed their reset values, so a
   // CS held low across reset cannot look like a fresh falling edge.
   assign w_sync_ok  = (r_flush_cnt == c_FLUSH);
   assign w_sck_rise = w_sync_ok &  w_sck  & ~r_sck_d;
   assign w_cs_fall  = w_sync_ok & ~w_cs_n &  r_cs_d;
   assign w_cs_rise  = w_sync_ok &  w_cs_n & ~r_cs_d;

   // Synchronise the asynchronous SPI pins and count off the post-reset flush
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sck_sync  <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sck_d     <= 1'b0;
         r_cs_d      <= 1'b1;
         r_flush_cnt <= '0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_sck_d     <= w_sck;
         r_cs_d      <= w_cs_n;
         if (!w_sync_ok) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   // Receiver state register, bit counter and shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
      end
   end

   // Receiver next state: CS framing, MSB-first shifting, push on 8th bit
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_push        = 1'b0;
      w_push_byte   = {r_shift[6:0], w_mosi};
      case (r_state)
         ST_IDLE: begin
            w_bit_cnt_nxt = '0;
            if (w_cs_fall) begin
               w_shift_nxt = '0;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A CS rise discards any partial byte and beats a coincident sck edge
            if (w_cs_rise) begin
               w_state_nxt   = ST_IDLE;
               w_bit_cnt_nxt = '0;
               w_shift_nxt   = '0;
            end else if (w_sck_rise) begin
               w_shift_nxt = w_push_byte;
               if (r_bit_cnt == 3'd7) begin
                  w_push        = 1'b1;
                  w_bit_cnt_nxt = '0;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign rx_active = (r_state == ST_SHIFT);

   // A pop on a full FIFO frees the slot the simultaneous push needs
   assign w_full  = (r_level == c_DEPTH);
   assign w_pop   = next & (r_level != '0);
   assign w_wr_en = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   // Byte storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr] <= w_push_byte;
   end

   // FIFO pointers, entry count and sticky overflow flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_en, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_drop)              r_overflow <= 1'b1;
         else if (clear_overflow) r_overflow <= 1'b0;
      end
   end

`ifdef CMD_RX_DROP_COUNT_EN
   logic [15:0] r_drop_cnt;

   // Saturating count of dropped bytes; a drop coincident with clear leaves 1
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         if (clear_overflow)             r_drop_cnt <= 16'd1;
         else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end else if (clear_overflow) begin
         r_drop_cnt <= '0;
      end
   end

   assign dropped_count = r_drop_cnt;
`endif

   // Head byte is gated by the registered count so it reads 0 when empty
   assign out_valid  = (r_level != '0);
   assign out_byte   = out_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign overflow   = r_overflow;
   assign fifo_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_cmd_spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_spi_rx_fifo
// Brief    : Self-checking bench for cmd_spi_rx_fifo; SPI frames are bit-banged
//            at clk/8 and results compared against a queue-based byte model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_spi_rx_fifo;

   localparam int DEPTH = 64;
   localparam int SYNC  = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_sck = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       next = 1'b0;
   logic       clear_overflow = 1'b0;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       overflow;
   logic [6:0] fifo_level;
   logic       rx_active;
`ifdef CMD_RX_DROP_COUNT_EN
   logic [15:0] dropped_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: queue of accepted bytes, sticky overflow, drop count
   logic [7:0] model_q [$];
   logic       model_ovf = 1'b0;
   int         model_drops = 0;

   always #5 clk = ~clk;

   cmd_spi_rx_fifo #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk            (clk),
      .reset          (reset),
      .spi_sck        (spi_sck),
      .spi_cs_n       (spi_cs_n),
      .spi_mosi       (spi_mosi),
      .out_byte       (out_byte),
      .out_valid      (out_valid),
      .next           (next),
      .overflow       (overflow),
      .clear_overflow (clear_overflow),
      .fifo_level     (fifo_level),
      .rx_active      (rx_active)
`ifdef CMD_RX_DROP_COUNT_EN
      ,
      .dropped_count  (dropped_count)
`endif
   );

   function automatic void model_push(input logic [7:0] b);
      if (model_q.size() < DEPTH) begin
         model_q.push_back(b);
      end else begin
         model_ovf = 1'b1;
         if (model_drops < 65535) model_drops++;
      end
   endfunction

   function automatic void model_reset();
      model_q.delete();
      model_ovf   = 1'b0;
      model_drops = 0;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
   endtask

   // One mode-0 bit: data set while sck low, 4 clk low then 4 clk high
   task automatic spi_bit(input logic b);
      @(negedge clk);
      spi_mosi = b;
      spi_sck  = 1'b0;
      repeat (3) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic cs_low();
      @(negedge clk);
      spi_cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (4) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic pulse_next();
      @(negedge clk);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (out_valid !== 1'b0 || out_byte !== 8'h00 || overflow !== 1'b0 ||
          fifo_level !== 7'd0 || rx_active !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: valid=%b byte=%h ovf=%b level=%0d active=%b, required all 0",
                  out_valid, out_byte, overflow, fifo_level, rx_active);
      end
   endtask

   task automatic test_basic();
      do_reset();
      cs_low();
      n_tests++;
      if (rx_active !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_rx_active: got %b, required 1", rx_active);
      end
      spi_byte(8'hA5); model_push(8'hA5);
      spi_byte(8'h3C); model_push(8'h3C);
      cs_high();
      n_tests++;
      if (out_valid !== 1'b1 || out_byte !== 8'hA5 || fifo_level !== 7'd2 || rx_active !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_frame: valid=%b byte=%h level=%0d active=%b, required 1 a5 2 0",
                  out_valid, out_byte, fifo_level, rx_active);
      end
      pulse_next(); void'(model_q.pop_front());
      n_tests++;
      if (out_byte !== model_q[0] || fifo_level !== 7'd1) begin
         n_fail++;
         $display("FAIL basic_pop1: byte=%h level=%0d, required %h 1", out_byte, fifo_level, model_q[0]);
      end
      pulse_next(); void'(model_q.pop_front());
      n_tests++;
      if (out_valid !== 1'b0 || fifo_level !== 7'd0) begin
         n_fail++;
         $display("FAIL basic_pop2: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
      end
   endtask

   task automatic test_abort();
      do_reset();
      cs_low();
      spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0);
      cs_high();
      cs_low();
      spi_byte(8'h81); model_push(8'h81);
      cs_high();
      n_tests++;
      if (fifo_level !== 7'(model_q.size()) || out_byte !== model_q[0]) begin
         n_fail++;
         $display("FAIL abort: level=%0d byte=%h, required %0d %h",
                  fifo_level, out_byte, model_q.size(), model_q[0]);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      cs_low();
      for (int i = 0; i < DEPTH + 3; i++) begin
         spi_byte(8'(i));
         model_push(8'(i));
      end
      cs_high();
      n_tests++;
      if (fifo_level !== 7'(model_q.size()) || overflow !== model_ovf || out_byte !== model_q[0]) begin
         n_fail++;
         $display("FAIL overflow_state: level=%0d ovf=%b head=%h, required %0d %b %h",
                  fifo_level, overflow, out_byte, model_q.size(), model_ovf, model_q[0]);
      end
`ifdef CMD_RX_DROP_COUNT_EN
      n_tests++;
      if (dropped_count !== 16'(model_drops)) begin
         n_fail++;
         $display("FAIL drop_count: got %0d, required %0d", dropped_count, model_drops);
      end
`endif
      @(negedge clk); clear_overflow = 1'b1;
      @(negedge clk); clear_overflow = 1'b0;
      model_ovf = 1'b0; model_drops = 0;
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_overflow: got %b, required 0", overflow);
      end
`ifdef CMD_RX_DROP_COUNT_EN
      n_tests++;
      if (dropped_count !== 16'd0) begin
         n_fail++;
         $display("FAIL drop_count_clear: got %0d, required 0", dropped_count);
      end
`endif
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++;
         if (out_valid !== 1'b1 || out_byte !== model_q[0]) begin
            n_fail++;
            $display("FAIL overflow_drain[%0d]: valid=%b byte=%h, required 1 %h",
                     i, out_valid, out_byte, model_q[0]);
         end
         pulse_next();
         void'(model_q.pop_front());
      end
      n_tests++;
      if (out_valid !== 1'b0 || fifo_level !== 7'd0) begin
         n_fail++;
         $display("FAIL overflow_empty: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
      end
   endtask

   // Fill to full, then land a pop on the very edge that pushes 0x77
   task automatic test_full_push_pop();
      logic [7:0] b;
      do_reset();
      cs_low();
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         spi_byte(b);
         model_push(b);
      end
      b = 8'h77;
      for (int i = 7; i >= 1; i--) spi_bit(b[i]);
      @(negedge clk);
      spi_mosi = b[0];
      repeat (3) @(negedge clk);
      spi_sck = 1'b1;
      // sck seen after SYNC stages, edge flagged one cycle later, push on the next edge
      repeat (SYNC) @(negedge clk);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      void'(model_q.pop_front());
      model_push(8'h77);
      repeat (2) @(negedge clk);
      spi_sck = 1'b0;
      cs_high();
      n_tests++;
      if (fifo_level !== 7'(DEPTH) || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL full_push_pop: level=%0d ovf=%b, required %0d 0", fifo_level, overflow, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_tests++;
         if (out_byte !== model_q[0]) begin
            n_fail++;
            $display("FAIL full_push_pop_drain[%0d]: byte=%h, required %h", i, out_byte, model_q[0]);
         end
         pulse_next();
         void'(model_q.pop_front());
      end
   endtask

   task automatic test_empty_pop();
      do_reset();
      pulse_next();
      n_tests++;
      if (out_valid !== 1'b0 || fifo_level !== 7'd0) begin
         n_fail++;
         $display("FAIL empty_pop: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
      end
      cs_low();
      spi_byte(8'h11);
      spi_byte(8'h22);
      cs_high();
      @(negedge clk); next = 1'b1;
      repeat (3) @(negedge clk);
      next = 1'b0;
      n_tests++;
      if (out_valid !== 1'b0 || fifo_level !== 7'd0) begin
         n_fail++;
         $display("FAIL hold_next: valid=%b level=%0d, required 0 0", out_valid, fifo_level);
      end
      cs_low();
      spi_byte(8'h33);
      cs_high();
      n_tests++;
      if (fifo_level !== 7'd1 || out_byte !== 8'h33) begin
         n_fail++;
         $display("FAIL no_underflow: level=%0d byte=%h, required 1 33", fifo_level, out_byte);
      end
   endtask

   task automatic test_reset_mid_byte();
      do_reset();
      cs_low();
      spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h03);
      spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      model_reset();
      n_tests++;
      if (out_valid !== 1'b0 || out_byte !== 8'h00 || overflow !== 1'b0 ||
          fifo_level !== 7'd0 || rx_active !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: valid=%b byte=%h ovf=%b level=%0d active=%b, required all 0",
                  out_valid, out_byte, overflow, fifo_level, rx_active);
      end
      spi_byte(8'hFF);
      spi_byte(8'h96);
      n_tests++;
      if (fifo_level !== 7'd0 || rx_active !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_same_cs: level=%0d active=%b, required 0 0", fifo_level, rx_active);
      end
      cs_high();
      cs_low();
      spi_byte(8'h5A); model_push(8'h5A);
      cs_high();
      n_tests++;
      if (out_byte !== model_q[0] || fifo_level !== 7'd1) begin
         n_fail++;
         $display("FAIL reset_new_frame: byte=%h level=%0d, required %h 1", out_byte, fifo_level, model_q[0]);
      end
   endtask

   // Random frames, random aborted tails and random pop counts against the model
   task automatic test_random();
      logic [7:0] b;
      int         nb;
      int         np;
      do_reset();
      for (int r = 0; r < 8; r++) begin
         nb = int'($urandom_range(1, 5));
         cs_low();
         for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            spi_byte(b);
            model_push(b);
         end
         if ($urandom_range(0, 1) == 1) begin
            np = int'($urandom_range(1, 7));
            for (int i = 0; i < np; i++) spi_bit(1'($urandom));
         end
         cs_high();
         n_tests++;
         if (fifo_level !== 7'(model_q.size()) || out_valid !== (model_q.size() != 0)) begin
            n_fail++;
            $display("FAIL random_level[%0d]: level=%0d valid=%b, required %0d", r, fifo_level,
                     out_valid, model_q.size());
         end
         np = int'($urandom_range(0, model_q.size()));
         for (int i = 0; i < np; i++) begin
            n_tests++;
            if (out_byte !== model_q[0]) begin
               n_fail++;
               $display("FAIL random_head[%0d.%0d]: byte=%h, required %h", r, i, out_byte, model_q[0]);
            end
            pulse_next();
            void'(model_q.pop_front());
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_abort();
      test_overflow();
      test_full_push_pop();
      test_empty_pop();
      test_reset_mid_byte();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmd_spi_rx_fifo.md
Name: cmd_spi_rx_fifo

Overview:
- Upstream byte source for the control unit: a mode-0 SPI slave receiver from the host MCU, followed by a byte FIFO.
- Presents one byte at a time on out_byte/out_valid and pops the byte when the control unit pulses next.
- Decouples SPI burst timing from control-unit stalls, e.g. while it waits on a pipeline swap, reset or regfile sync.

Parameters:
- FIFO_DEPTH, 64, number of byte entries; must be a power of two, ≥4.
- SYNC_STAGES, 2, flip-flop stages on spi_sck, spi_cs_n and spi_mosi; ≥2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- spi_sck  input  1  async SPI clock, mode 0; frequency ≤ clk/4.
- spi_cs_n  input  1  async chip select, active-low.
- spi_mosi  input  1  async serial data, MSB first.
- out_byte  output  8  FIFO head byte.
- out_valid  output  1  FIFO non-empty.
- next  input  1  single-cycle pop strobe from the control unit.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- clear_overflow  input  1  clears overflow.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
- rx_active  output  1  synced CS asserted.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset:
  - Read/write pointers, level, bit counter and shift register go to 0.
  - out_valid=0, out_byte=0, overflow=0, fifo_level=0, rx_active=0.
  - Synchroniser chains reset to sck=0, cs_n=1, mosi=0.
- Synchronisers: SYNC_STAGES flops per input. Edge detect on the last stage against one extra delayed flop.
- Receiver FSM, state IDLE (cs_n synced high):
  - Bit counter is held at 0.
  - On a cs_n falling edge: clear the bit counter and shift register, go to SHIFT.
- Receiver FSM, state SHIFT:
  - On each synced sck rising edge: shift synced mosi into the LSB (shift left) and increment the bit counter.
  - When the 8th bit is captured: assert an internal push for exactly one cycle with the assembled byte, reset the counter to 0 and stay in SHIFT.
  - On a cs_n rising edge: return to IDLE and discard the partial byte. No push occurs.
  - If an sck edge and a cs_n rise are detected in the same cycle, the cs_n rise wins and the edge is ignored.
- rx_active = state==SHIFT.
- FIFO storage: registered memory (inferable as RAM or LUTs). out_byte = mem[rd_ptr], read combinationally from the registered pointer, so it is a registered-path output.
- Push:
  - If level<FIFO_DEPTH, write and increment wr_ptr; pointers wrap modulo FIFO_DEPTH.
  - If full, drop the byte and set overflow on the same edge.
- Pop: a clock edge with next=1 and out_valid=1 increments rd_ptr. next with out_valid=0 is ignored, with no pointer or level change.
- Simultaneous push and pop:
  - Level unchanged; both pointers advance.
  - When full, the pop frees a slot, so the push is accepted and overflow is not set.
- Latency:
  - Byte pushed at edge N → out_valid=1 and out_byte valid after edge N (visible in cycle N+1), provided the FIFO was empty.
  - Pop at edge N → the new head is visible after edge N.
  - The control unit's one-cycle wait_one gap is therefore always satisfied.
- out_valid = (level!=0). fifo_level equals the registered count.
- clear_overflow: clears overflow at that edge. If a drop occurs on the same edge, overflow stays 1.
- Reset mid-byte or mid-burst:
  - All state goes to its reset value and FIFO contents are discarded.
  - If CS is still low after reset, the receiver stays in IDLE until the next cs_n falling edge, so no mis-framed bytes are produced.

Optional Feature:
- Macro CMD_RX_DROP_COUNT_EN.
- Defined:
  - Adds output dropped_count, 16 bits.
  - Increments saturating at 16'hFFFF for each dropped byte.
  - Cleared by reset and by clear_overflow. If clear and drop coincide, the result is 1.
- Undefined: port and counter are absent; overflow behaviour is unchanged.

Test Plan:
- Send one CS frame carrying 0xA5, 0x3C at sck=clk/8 with next held low → out_valid=1, out_byte=0xA5, fifo_level=2. Pulse next → out_byte=0x3C the next cycle. Pulse next again → out_valid=0, fifo_level=0.
- Send 5 bits 10110 then raise cs_n, then a new frame carrying 0x81 → only 0x81 is queued; fifo_level=1.
- Send FIFO_DEPTH+3 bytes (0x00..0x42) with no pops → fifo_level=64, overflow=1, head=0x00. After 64 pops the last byte read is 0x3F. With CMD_RX_DROP_COUNT_EN, dropped_count=3.
- With the FIFO full, pulse next on the same edge as an internal push of 0x77 → level stays 64, overflow stays 0, 0x77 is the last entry.
- Pulse next with the FIFO empty → no change, out_valid=0, fifo_level=0. Hold next high for 3 cycles with 2 entries queued → both pop, level=0, no underflow.
- Assert reset for 1 cycle mid-byte, with 3 bytes queued and CS low → all outputs at reset values. Subsequent sck edges under the same CS produce no bytes. A new CS frame carrying 0x5A → out_byte=0x5A.
